// File: rtl/grid_pkg.sv
// Shared constants, FSM state type and cell addressing for the grid stream transmitter.
package grid_pkg;

    localparam int unsigned GRID_N     = 5;
    localparam int unsigned CELLS_TX   = 23;
    localparam int unsigned PATH_BEATS = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT,
        S_RECV,
        S_DONE
    } state_t;

    // Row-major cell index y*GRID_N+x; 4*5+4 = 24 fits in 5 bits.
    function automatic logic [4:0] cell_idx(input logic [2:0] x, input logic [2:0] y);
        return 5'(y) * 5'(GRID_N) + 5'(x);
    endfunction

endpackage

// File: rtl/grid_stream_tx_if.sv
// CHIP-facing stream: cost cells out, path beats back.
interface grid_stream_tx_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SUM_W  = 16
);
    logic              IN_VALID;
    logic [DATA_W-1:0] IN_DATA;
    logic              OUT_VALID;
    logic [3:0]        OUT_DATA_X;
    logic [3:0]        OUT_DATA_Y;
    logic [SUM_W-1:0]  OUT_DATA_SUM;

    modport master (
        output IN_VALID, IN_DATA,
        input  OUT_VALID, OUT_DATA_X, OUT_DATA_Y, OUT_DATA_SUM
    );

    modport slave (
        input  IN_VALID, IN_DATA,
        output OUT_VALID, OUT_DATA_X, OUT_DATA_Y, OUT_DATA_SUM
    );
endinterface

// File: rtl/grid_path_checker.sv
// Path beat legality and capture counters (step count, last sum, previous coordinate).
module grid_path_checker
    import grid_pkg::*;
#(
    parameter int unsigned SUM_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             beat_i,
    input  logic [3:0]       x_i,
    input  logic [3:0]       y_i,
    input  logic [SUM_W-1:0] sum_i,
    output logic             beat_ok_o,
    output logic             path_ok_o,
    output logic [3:0]       step_cnt_o,
    output logic [SUM_W-1:0] last_sum_o
);

    logic [3:0]       px_q, py_q, step_q;
    logic [SUM_W-1:0] last_q;
    logic [3:0]       diag_new, diag_want;

    // A beat must advance one diagonal, move only right/down, stay on the grid
    // and never decrease the running sum (except the first beat).
    always_comb begin
        diag_new  = x_i + y_i;
        diag_want = px_q + py_q + 4'd1;
        beat_ok_o = (diag_new == diag_want)
                 && (x_i >= px_q) && (y_i >= py_q)
                 && (x_i <= 4'(GRID_N - 1)) && (y_i <= 4'(GRID_N - 1))
                 && ((step_q == 4'd0) || (sum_i >= last_q));
        // Starting from (0,0), each legal step adds one to X+Y, so the
        // required end diagonal equals the required beat count.
        path_ok_o = (step_q == 4'(PATH_BEATS)) && ((px_q + py_q) == 4'(PATH_BEATS));
    end

    // Capture registers: cleared on START, updated on every accepted beat.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            px_q   <= '0;
            py_q   <= '0;
            step_q <= '0;
            last_q <= '0;
        end else if (clr_i) begin
            px_q   <= '0;
            py_q   <= '0;
            step_q <= '0;
            last_q <= '0;
        end else if (beat_i) begin
            px_q   <= x_i;
            py_q   <= y_i;
            last_q <= sum_i;
            if (step_q != 4'hF) begin
                step_q <= step_q + 4'd1;
            end
        end
    end

    assign step_cnt_o = step_q;
    assign last_sum_o = last_q;

endmodule

// File: rtl/grid_stream_tx.sv
// Host-side CHIP driver: streams 23 non-corner grid cells, then captures and
// validates the returned path beats with a per-gap timeout.
module grid_stream_tx
    import grid_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned SUM_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              CFG_WE,
    input  logic [4:0]        CFG_ADDR,
    input  logic [DATA_W-1:0] CFG_DATA,
    input  logic              START,
    output logic              BUSY,
    grid_stream_tx_if.master  chip,
    output logic              DONE,
    output logic              ERR,
    output logic              TMO,
    output logic [SUM_W-1:0]  LAST_SUM,
    output logic [3:0]        STEP_CNT
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned NCELL = GRID_N * GRID_N;

    state_t            state_q;
    logic [DATA_W-1:0] grid_q [NCELL];
    logic              in_valid_q;
    logic [DATA_W-1:0] in_data_q;
    logic [2:0]        x_q, y_q, x_d, y_d;
    logic [TMO_W-1:0]  tmo_cnt_q;
    logic              busy_q, done_q, err_q, tmo_q, vld_prev_q;
    logic              cfg_ok, kick, last_tx, tmo_hit, capture, beat_ok, path_ok;
    logic [DATA_W-1:0] first_data;

    assign cfg_ok  = CFG_WE && (state_q == S_IDLE)
                  && (CFG_ADDR != 5'd0) && (CFG_ADDR <= 5'(CELLS_TX));
    assign kick    = START && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign capture = chip.OUT_VALID && ((state_q == S_WAIT) || (state_q == S_RECV));
    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT - 1));
    assign last_tx = (x_q == 3'(GRID_N - 2)) && (y_q == 3'(GRID_N - 1));

    // Next streamed coordinate in row-major order; corners are skipped by the
    // start point (1,0) and the end point (3,4).
    always_comb begin
        x_d = x_q + 3'd1;
        y_d = y_q;
        if (x_q == 3'(GRID_N - 1)) begin
            x_d = '0;
            y_d = y_q + 3'd1;
        end
        // A write landing on the same edge as START must reach the first beat.
        first_data = grid_q[cell_idx(3'd1, 3'd0)];
        if (cfg_ok && (CFG_ADDR == cell_idx(3'd1, 3'd0))) begin
            first_data = CFG_DATA;
        end
    end

    // Grid store; only the streamed cells are writable, corners stay zero.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < NCELL; i++) begin
                grid_q[i] <= '0;
            end
        end else if (cfg_ok) begin
            grid_q[CFG_ADDR] <= CFG_DATA;
        end
    end

    // Control FSM with stream sequencer and timeout counter.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            in_valid_q <= 1'b0;
            in_data_q  <= '0;
            x_q        <= '0;
            y_q        <= '0;
            tmo_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= 1'b0;
            vld_prev_q <= 1'b0;
        end else begin
            vld_prev_q <= chip.OUT_VALID;
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (kick) begin
                        state_q    <= S_SEND;
                        in_valid_q <= 1'b1;
                        in_data_q  <= first_data;
                        x_q        <= 3'd1;
                        y_q        <= 3'd0;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        tmo_q      <= 1'b0;
                    end
                end
                S_SEND: begin
                    if (last_tx) begin
                        state_q    <= S_WAIT;
                        in_valid_q <= 1'b0;
                        in_data_q  <= '0;
                        tmo_cnt_q  <= '0;
                    end else begin
                        x_q       <= x_d;
                        y_q       <= y_d;
                        in_data_q <= grid_q[cell_idx(x_d, y_d)];
                    end
                end
                S_WAIT: begin
                    if (chip.OUT_VALID) begin
                        state_q   <= S_RECV;
                        tmo_cnt_q <= '0;
                        if (!beat_ok) err_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                S_RECV: begin
                    if (chip.OUT_VALID) begin
                        tmo_cnt_q <= '0;
                        if (!beat_ok) err_q <= 1'b1;
                    end else if (vld_prev_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        if (!path_ok) err_q <= 1'b1;
                    end else if (tmo_hit) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        tmo_q   <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    grid_path_checker #(
        .SUM_W(SUM_W)
    ) u_chk (
        .clk_i      (CLK),
        .rst_ni     (RESET_N),
        .clr_i      (kick),
        .beat_i     (capture),
        .x_i        (chip.OUT_DATA_X),
        .y_i        (chip.OUT_DATA_Y),
        .sum_i      (chip.OUT_DATA_SUM),
        .beat_ok_o  (beat_ok),
        .path_ok_o  (path_ok),
        .step_cnt_o (STEP_CNT),
        .last_sum_o (LAST_SUM)
    );

    assign chip.IN_VALID = in_valid_q;
    assign chip.IN_DATA  = in_data_q;
    assign BUSY          = busy_q;
    assign DONE          = done_q;
    assign ERR           = err_q;
    assign TMO           = tmo_q;

endmodule

// File: tb/tb_grid_stream_tx.sv
// Bench for grid_stream_tx: IN_DATA scoreboard plus table of path responses.
module tb_grid_stream_tx;

    localparam int DATA_W  = 8;
    localparam int SUM_W   = 16;
    localparam int TIMEOUT = 64;

    logic              CLK      = 1'b0;
    logic              RESET_N  = 1'b0;
    logic              CFG_WE   = 1'b0;
    logic [4:0]        CFG_ADDR = '0;
    logic [DATA_W-1:0] CFG_DATA = '0;
    logic              START    = 1'b0;
    logic              BUSY, DONE, ERR, TMO;
    logic [SUM_W-1:0]  LAST_SUM;
    logic [3:0]        STEP_CNT;

    grid_stream_tx_if #(.DATA_W(DATA_W), .SUM_W(SUM_W)) chip ();

    grid_stream_tx #(.DATA_W(DATA_W), .SUM_W(SUM_W), .TIMEOUT(TIMEOUT)) dut (
        .CLK      (CLK),
        .RESET_N  (RESET_N),
        .CFG_WE   (CFG_WE),
        .CFG_ADDR (CFG_ADDR),
        .CFG_DATA (CFG_DATA),
        .START    (START),
        .BUSY     (BUSY),
        .chip     (chip),
        .DONE     (DONE),
        .ERR      (ERR),
        .TMO      (TMO),
        .LAST_SUM (LAST_SUM),
        .STEP_CNT (STEP_CNT)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string name;
        int    nb;
        int    xs[8];
        int    ys[8];
        int    sums[8];
        int    err;
        int    step;
        int    last;
    } resp_t;

    resp_t tv[7];
    int    model[25];
    int    exp_q[$];
    int    n_vec = 0;
    int    n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
        end
    endtask

    // IN_DATA scoreboard: every valid beat pops the next expected cell.
    always @(negedge CLK) begin
        if (RESET_N && chip.IN_VALID === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_in_beat: IN_DATA=%0d with nothing expected", chip.IN_DATA);
            end else begin
                chk("IN_DATA", 32'(chip.IN_DATA), exp_q.pop_front());
            end
        end
    end

    task automatic cfg_wr(input int a, input int d);
        CFG_WE   = 1'b1;
        CFG_ADDR = 5'(a);
        CFG_DATA = 8'(d);
        @(negedge CLK);
        CFG_WE   = 1'b0;
    endtask

    // START one stream; optional write on the START cycle and a write poked mid-SEND.
    task automatic run_send(input bit wr, input int wa, input int wd, input bit poke);
        int n   = 0;
        int blo = 0;
        for (int i = 1; i <= 23; i++) exp_q.push_back(model[i]);
        START = 1'b1;
        if (wr) begin
            CFG_WE   = 1'b1;
            CFG_ADDR = 5'(wa);
            CFG_DATA = 8'(wd);
        end
        @(negedge CLK);
        START  = 1'b0;
        CFG_WE = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (chip.IN_VALID === 1'b1) begin
                n++;
                if (BUSY !== 1'b1) blo++;
            end else if (n > 0) begin
                break;
            end
            if (poke && n == 5) begin
                CFG_WE   = 1'b1;
                CFG_ADDR = 5'd5;
                CFG_DATA = 8'hEE;
            end else begin
                CFG_WE = 1'b0;
            end
            @(negedge CLK);
        end
        CFG_WE = 1'b0;
        chk("IN_VALID_cycles", n, 23);
        chk("BUSY_low_in_send", blo, 0);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic wait_done(input int limit, output int cyc);
        cyc = 0;
        while (DONE !== 1'b1 && cyc < limit) begin
            @(negedge CLK);
            cyc++;
        end
        if (DONE !== 1'b1) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_wait: DONE=%b after %0d cycles, required 1", DONE, cyc);
        end
    endtask

    task automatic respond(input resp_t v, input bit poke_start);
        int cyc;
        if (poke_start) begin
            START = 1'b1;
            @(negedge CLK);
            START = 1'b0;
        end
        repeat (2) @(negedge CLK);
        for (int b = 0; b < v.nb; b++) begin
            chip.OUT_VALID    = 1'b1;
            chip.OUT_DATA_X   = 4'(v.xs[b]);
            chip.OUT_DATA_Y   = 4'(v.ys[b]);
            chip.OUT_DATA_SUM = 16'(v.sums[b]);
            @(negedge CLK);
        end
        chip.OUT_VALID = 1'b0;
        wait_done(20, cyc);
        chk({v.name, "_ERR"}, 32'(ERR), v.err);
        chk({v.name, "_TMO"}, 32'(TMO), 0);
        chk({v.name, "_STEP_CNT"}, 32'(STEP_CNT), v.step);
        chk({v.name, "_LAST_SUM"}, 32'(LAST_SUM), v.last);
        chk({v.name, "_BUSY"}, 32'(BUSY), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors so far", n_vec);
        $fatal(1);
    end

    initial begin
        int cyc;
        chip.OUT_VALID    = 1'b0;
        chip.OUT_DATA_X   = '0;
        chip.OUT_DATA_Y   = '0;
        chip.OUT_DATA_SUM = '0;
        for (int i = 0; i < 25; i++) model[i] = 0;

        tv[0].name = "legal";   tv[0].nb = 7; tv[0].xs = '{1,2,3,4,4,4,4,0}; tv[0].ys = '{0,0,0,0,1,2,3,0}; tv[0].sums = '{1,3,6,10,19,33,52,0}; tv[0].err = 0; tv[0].step = 7; tv[0].last = 52;
        tv[1].name = "legal_b"; tv[1].nb = 7; tv[1].xs = '{0,1,1,2,2,3,3,0}; tv[1].ys = '{1,1,2,2,3,3,4,0}; tv[1].sums = '{5,5,6,6,7,8,9,0};     tv[1].err = 0; tv[1].step = 7; tv[1].last = 9;
        tv[2].name = "diag";    tv[2].nb = 2; tv[2].xs = '{1,2,0,0,0,0,0,0}; tv[2].ys = '{0,1,0,0,0,0,0,0}; tv[2].sums = '{5,9,0,0,0,0,0,0};     tv[2].err = 1; tv[2].step = 2; tv[2].last = 9;
        tv[3].name = "short";   tv[3].nb = 5; tv[3].xs = '{1,2,3,4,4,0,0,0}; tv[3].ys = '{0,0,0,0,1,0,0,0}; tv[3].sums = '{1,3,6,10,19,0,0,0};   tv[3].err = 1; tv[3].step = 5; tv[3].last = 19;
        tv[4].name = "sumdrop"; tv[4].nb = 7; tv[4].xs = '{1,2,3,4,4,4,4,0}; tv[4].ys = '{0,0,0,0,1,2,3,0}; tv[4].sums = '{1,3,6,5,19,33,52,0};  tv[4].err = 1; tv[4].step = 7; tv[4].last = 52;
        tv[5].name = "xrange";  tv[5].nb = 7; tv[5].xs = '{1,2,3,4,5,5,5,0}; tv[5].ys = '{0,0,0,0,0,1,2,0}; tv[5].sums = '{1,2,3,4,5,6,7,0};     tv[5].err = 1; tv[5].step = 7; tv[5].last = 7;
        tv[6].name = "xback";   tv[6].nb = 3; tv[6].xs = '{1,2,1,0,0,0,0,0}; tv[6].ys = '{0,0,2,0,0,0,0,0}; tv[6].sums = '{1,2,3,0,0,0,0,0};     tv[6].err = 1; tv[6].step = 3; tv[6].last = 3;

        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rst_IN_VALID", 32'(chip.IN_VALID), 0);
        chk("rst_IN_DATA", 32'(chip.IN_DATA), 0);
        chk("rst_BUSY", 32'(BUSY), 0);
        chk("rst_DONE", 32'(DONE), 0);
        chk("rst_ERR", 32'(ERR), 0);
        chk("rst_TMO", 32'(TMO), 0);
        chk("rst_LAST_SUM", 32'(LAST_SUM), 0);
        chk("rst_STEP_CNT", 32'(STEP_CNT), 0);

        // Empty grid streams zeros, then no response leads to timeout.
        run_send(1'b0, 0, 0, 1'b0);
        wait_done(100, cyc);
        chk("tmo_latency_in_63_65", 32'(cyc >= 63 && cyc <= 65), 1);
        chk("tmo_TMO", 32'(TMO), 1);
        chk("tmo_ERR", 32'(ERR), 1);
        chk("tmo_STEP_CNT", 32'(STEP_CNT), 0);
        chk("tmo_BUSY", 32'(BUSY), 0);

        // OUT_VALID while DONE is ignored.
        chip.OUT_VALID = 1'b1; chip.OUT_DATA_X = 4'd1; chip.OUT_DATA_Y = 4'd0; chip.OUT_DATA_SUM = 16'd5;
        repeat (2) @(negedge CLK);
        chip.OUT_VALID = 1'b0;
        @(negedge CLK);
        chk("done_ignore_STEP_CNT", 32'(STEP_CNT), 0);
        chk("done_ignore_LAST_SUM", 32'(LAST_SUM), 0);
        chk("done_held_DONE", 32'(DONE), 1);

        // Fresh reset, then load cells; writes to corners and out-of-range addresses drop.
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rst2_DONE", 32'(DONE), 0);
        chk("rst2_TMO", 32'(TMO), 0);
        for (int a = 1; a <= 22; a++) begin
            cfg_wr(a, a);
            model[a] = a;
        end
        cfg_wr(0, 8'hAA);
        cfg_wr(24, 8'hAA);
        cfg_wr(25, 8'hAA);
        cfg_wr(31, 8'hAA);
        model[23] = 23;
        run_send(1'b1, 23, 23, 1'b1);
        respond(tv[0], 1'b0);

        // Writes outside IDLE are ignored.
        cfg_wr(7, 8'h99);

        for (int k = 1; k < 7; k++) begin
            run_send(1'b0, 0, 0, 1'b0);
            respond(tv[k], k == 1);
        end

        // STEP_CNT saturates at 15.
        run_send(1'b0, 0, 0, 1'b0);
        repeat (2) @(negedge CLK);
        for (int b = 0; b < 16; b++) begin
            chip.OUT_VALID = 1'b1; chip.OUT_DATA_X = 4'd1; chip.OUT_DATA_Y = 4'd0; chip.OUT_DATA_SUM = 16'd1;
            @(negedge CLK);
        end
        chip.OUT_VALID = 1'b0;
        wait_done(20, cyc);
        chk("sat_STEP_CNT", 32'(STEP_CNT), 15);
        chk("sat_ERR", 32'(ERR), 1);
        chk("sat_LAST_SUM", 32'(LAST_SUM), 1);

        // Reset during the 10th SEND beat drops IN_VALID without a clock edge.
        for (int i = 1; i <= 23; i++) exp_q.push_back(model[i]);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (9) @(negedge CLK);
        chk("mid_IN_VALID_before", 32'(chip.IN_VALID), 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mid_IN_VALID_async", 32'(chip.IN_VALID), 0);
        chk("mid_BUSY_async", 32'(BUSY), 0);
        chk("mid_IN_DATA_async", 32'(chip.IN_DATA), 0);
        exp_q.delete();
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        for (int i = 0; i < 25; i++) model[i] = 0;
        @(negedge CLK);
        run_send(1'b0, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/grid_stream_tx.md
Name: grid_stream_tx

Overview:
- Host-side transmitter/monitor for the grid shortest-path CHIP interface.
- Holds a 5x5 grid of 8-bit cell costs and streams the 23 non-corner cells over IN_VALID/IN_DATA in the order CHIP consumes them.
- Then captures and validates CHIP's OUT_VALID/X/Y/SUM path stream.
- Used as the stimulus/response end in subsystem benches and on the FPGA test harness.

Parameters:
- DATA_W, 8, cell cost width; must match CHIP IN_DATA.
- SUM_W, 16, path sum width; must match OUT_DATA_SUM.
- TIMEOUT, 64, maximum cycles allowed between the last IN_VALID beat and the first OUT_VALID beat, and between consecutive OUT_VALID beats.

Ports:
- CLK  in  1  clock
- RESET_N  in  1  asynchronous active-low reset
- CFG_WE  in  1  grid write strobe; ignored unless state is IDLE
- CFG_ADDR  in  5  cell index y*5+x; 0..24; writes to 0, 24 and values >24 are dropped
- CFG_DATA  in  DATA_W  cell cost
- START  in  1  one-cycle pulse; begins a transaction when in IDLE or DONE
- BUSY  out  1  high in SEND, WAIT and RECV
- IN_VALID  out  1  to CHIP
- IN_DATA  out  DATA_W  to CHIP
- OUT_VALID  in  1  from CHIP
- OUT_DATA_X  in  4  from CHIP
- OUT_DATA_Y  in  4  from CHIP
- OUT_DATA_SUM  in  SUM_W  from CHIP
- DONE  out  1  high in DONE state, until the next START
- ERR  out  1  protocol or path error; sticky until the next START
- TMO  out  1  timeout occurred (also sets ERR)
- LAST_SUM  out  SUM_W  SUM of the last captured beat
- STEP_CNT  out  4  number of captured beats

Behaviour:
- Reset: all outputs 0, state IDLE, grid registers 0.
- States: IDLE, SEND, WAIT, RECV, DONE.
- IDLE/DONE + START:
  - Clear ERR, TMO, STEP_CNT, LAST_SUM.
  - Set prev coordinate to (0,0).
  - Go to SEND; IN_VALID rises on the next edge.
- SEND: IN_VALID=1 for exactly 23 consecutive cycles, no gaps. Beat order:
  - y=0, x=1..4
  - y=1..3, x=0..4
  - y=4, x=0..3
  - IN_DATA = grid[y*5+x], registered, aligned with IN_VALID.
  - After the 23rd beat: IN_VALID=0, go to WAIT, load the timeout counter.
- WAIT: on the first OUT_VALID, go to RECV and capture that beat the same cycle. If the counter reaches TIMEOUT: TMO=1, ERR=1, go to DONE.
- RECV: each OUT_VALID=1 cycle is one beat; the timeout counter reloads on every beat.
  - Beat is legal when:
    - X+Y = prevX+prevY+1
    - X>=prevX and Y>=prevY
    - X<=4 and Y<=4
    - SUM >= LAST_SUM (the first beat is exempt).
  - Illegal beat: ERR=1, keep capturing.
  - Every beat: STEP_CNT++ (saturates at 15), LAST_SUM<=SUM, prev<=(X,Y).
  - OUT_VALID falling (previous beat valid, current not) ends the capture: go to DONE.
  - At that point STEP_CNT must be 7 and the last beat must have X+Y=7; otherwise ERR=1.
  - A timeout in RECV: TMO=1, ERR=1, go to DONE.
- DONE: DONE=1 and outputs held; START re-arms. The grid persists across transactions.
- OUT_VALID while in IDLE, SEND or DONE is ignored.
- START while BUSY is ignored.
- CFG_WE together with START in IDLE: the write completes, and SEND uses the new value.
- RESET_N asserted mid-transaction: IN_VALID drops asynchronously, all state and grid registers clear.
- Widths: all coordinate compares are done at 4 bits; the X+Y sums are 4-bit adds and cannot overflow for legal ranges.

Decomposition:
- Shared package grid_pkg holds:
  - GRID_N=5, CELLS_TX=23, PATH_BEATS=7
  - the state enum
  - the cell index function y*5+x
- One sub-module, grid_path_checker: combinational/registered beat legality and the capture counters, fed by the FSM.
- Stream sequencer, grid store and timeout counter stay in the top level.

Test Plan:
- Reset then idle: outputs all 0; START with no grid writes gives 23 IN_DATA beats of 0 in the specified order, with IN_VALID high for exactly 23 cycles.
- Load cell i with value i (1..23), START: IN_DATA sequence is 1,2,...,23, contiguous; BUSY=1 throughout.
- Response model emits 7 legal beats (1,0),(2,0),(3,0),(4,0),(4,1),(4,2),(4,3) with SUMs 1,3,6,10,19,33,52: DONE=1, ERR=0, STEP_CNT=7, LAST_SUM=52.
- Illegal response: beat (1,0) then (2,1): ERR=1, capture continues, DONE after OUT_VALID falls.
- Response stops after 5 beats (OUT_VALID falls): ERR=1, STEP_CNT=5. No response at all: TMO=1, ERR=1 after TIMEOUT=64 cycles.
- RESET_N pulsed at beat 10 of SEND: IN_VALID=0 immediately, grid reads 0, next START streams zeros.
